// File: rtl/wash_cycle_ctrl.sv
// Multi-phase wash sequencer: checks and charges the balance on start,
// counts each programmable phase down in 1 s ticks, and supports pause and abort.
module wash_cycle_ctrl #(
    parameter int                  TICK_DIV  = 100000000,
    parameter int                  NPHASE    = 3,
    parameter logic [8*NPHASE-1:0] PHASE_SEC = {8'd10, 8'd30, 8'd20},
    parameter int                  PRICE     = 5,
    parameter int                  BAL_W     = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    on,
    input  logic                    abort,
    input  logic signed [BAL_W-1:0] bal,
    output logic                    busy,
    output logic [2:0]              phase,
    output logic [7:0]              phase_led,
    output logic [7:0]              rem_bcd,
    output logic                    charge,
    output logic                    reject,
    output logic                    done
);

    localparam int                       DIV_W    = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0]         DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [2:0]               PH_LAST  = 3'(NPHASE - 1);
    localparam logic signed [BAL_W-1:0]  PRICE_S  = BAL_W'(PRICE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       phase_q, phase_d;
    logic [6:0]       rem_q, rem_d;
    logic             busy_q, busy_d;
    logic [7:0]       led_q, led_d;
    logic [7:0]       bcd_q, bcd_d;
    logic             charge_q, charge_d;
    logic             reject_q, reject_d;
    logic             done_q, done_d;

    // A zero lane still runs for one tick; lanes above 99 cannot be displayed.
    function automatic logic [6:0] phase_len(input logic [2:0] k);
        logic [7:0] v;
        v = 8'd1;
        for (int i = 0; i < NPHASE; i++) begin
            if (k == 3'(i)) begin
                v = PHASE_SEC[8*i +: 8];
            end
        end
        if (v == 8'd0) begin
            return 7'd1;
        end else if (v > 8'd99) begin
            return 7'd99;
        end else begin
            return v[6:0];
        end
    endfunction

    function automatic logic [7:0] to_bcd(input logic [6:0] r);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = 4'(r / 7'd10);
        units = 4'(r % 7'd10);
        return {tens, units};
    endfunction

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        phase_d  = phase_q;
        rem_d    = rem_q;
        charge_d = 1'b0;
        reject_d = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    if (bal >= PRICE_S) begin
                        state_d  = S_RUN;
                        div_d    = '0;
                        phase_d  = 3'd0;
                        rem_d    = phase_len(3'd0);
                        charge_d = 1'b1;
                    end else begin
                        reject_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    div_d   = '0;
                    phase_d = 3'd0;
                    rem_d   = 7'd0;
                end else if (on) begin
                    if (div_q == DIV_LAST) begin
                        div_d = '0;
                        if (rem_q > 7'd1) begin
                            rem_d = rem_q - 7'd1;
                        end else if (phase_q != PH_LAST) begin
                            phase_d = phase_q + 3'd1;
                            rem_d   = phase_len(phase_q + 3'd1);
                        end else begin
                            state_d = S_DONE;
                            phase_d = 3'd0;
                            rem_d   = 7'd0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end else begin
                    div_d = div_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                div_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                div_d   = '0;
                phase_d = 3'd0;
                rem_d   = 7'd0;
            end
        endcase
        busy_d = (state_d == S_RUN);
        led_d  = busy_d ? (8'd1 << phase_d) : 8'd0;
        bcd_d  = to_bcd(rem_d);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            div_q    <= '0;
            phase_q  <= 3'd0;
            rem_q    <= 7'd0;
            busy_q   <= 1'b0;
            led_q    <= 8'd0;
            bcd_q    <= 8'h00;
            charge_q <= 1'b0;
            reject_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            phase_q  <= phase_d;
            rem_q    <= rem_d;
            busy_q   <= busy_d;
            led_q    <= led_d;
            bcd_q    <= bcd_d;
            charge_q <= charge_d;
            reject_q <= reject_d;
            done_q   <= done_d;
        end
    end

    assign busy      = busy_q;
    assign phase     = phase_q;
    assign phase_led = led_q;
    assign rem_bcd   = bcd_q;
    assign charge    = charge_q;
    assign reject    = reject_q;
    assign done      = done_q;

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Directed bench for wash_cycle_ctrl: per-cycle vector table plus
// hand-written pause, zero/99-lane and asynchronous reset sequences.
module tb_wash_cycle_ctrl;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               start2 = 1'b0;
    logic               on = 1'b0;
    logic               abort = 1'b0;
    logic signed [11:0] bal = 12'sd0;

    logic       busy, charge, reject, done;
    logic [2:0] phase;
    logic [7:0] phase_led, rem_bcd;
    logic       busy2, charge2, reject2, done2;
    logic [2:0] phase2;
    logic [7:0] phase_led2, rem_bcd2;

    int n_cmp = 0;
    int n_err = 0;

    wash_cycle_ctrl #(
        .TICK_DIV(4), .NPHASE(3), .PHASE_SEC({8'd2, 8'd3, 8'd1}), .PRICE(5), .BAL_W(12)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .on(on), .abort(abort), .bal(bal),
        .busy(busy), .phase(phase), .phase_led(phase_led), .rem_bcd(rem_bcd),
        .charge(charge), .reject(reject), .done(done)
    );

    wash_cycle_ctrl #(
        .TICK_DIV(2), .NPHASE(2), .PHASE_SEC({8'd99, 8'd0}), .PRICE(5), .BAL_W(12)
    ) dut2 (
        .clk(clk), .rst(rst), .start(start2), .on(on), .abort(abort), .bal(bal),
        .busy(busy2), .phase(phase2), .phase_led(phase_led2), .rem_bcd(rem_bcd2),
        .charge(charge2), .reject(reject2), .done(done2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic       en;
        logic       ab;
        logic [11:0] b;
        logic       bz;
        logic [2:0] ph;
        logic [7:0] rm;
        logic       chg;
        logic       rej;
        logic       dn;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic st, input logic en, input logic ab, input logic [11:0] b,
                       input logic bz, input logic [2:0] ph, input logic [7:0] rm,
                       input logic chg, input logic rej, input logic dn);
        vec_t v;
        v.st = st; v.en = en; v.ab = ab; v.b = b; v.bz = bz;
        v.ph = ph; v.rm = rm; v.chg = chg; v.rej = rej; v.dn = dn;
        tbl.push_back(v);
    endtask

    task automatic hold(input int n, input logic st, input logic [2:0] ph, input logic [7:0] rm);
        repeat (n) add(st, 1'b1, 1'b0, 12'd5, 1'b1, ph, rm, 1'b0, 1'b0, 1'b0);
    endtask

    // One full cycle with phases {1,3,2} s at 4 clk per tick, then the IDLE return
    task automatic add_cycle(input logic st);
        add(1'b1, 1'b1, 1'b0, 12'd5, 1'b1, 3'd0, 8'h01, 1'b1, 1'b0, 1'b0);
        hold(3, st, 3'd0, 8'h01);
        hold(4, st, 3'd1, 8'h03);
        hold(4, st, 3'd1, 8'h02);
        hold(4, st, 3'd1, 8'h01);
        hold(4, st, 3'd2, 8'h02);
        hold(4, st, 3'd2, 8'h01);
        add(st, 1'b1, 1'b0, 12'd5, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1);
        add(st, 1'b1, 1'b0, 12'd5, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  cnt;
        bit  seen;
        vec_t v;

        add_cycle(1'b0);
        add(1'b1, 1'b1, 1'b0, 12'd4,   1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b1, 1'b0, 12'hFFF, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0);
        add(1'b1, 1'b1, 1'b1, 12'd5,   1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 12'd5,   1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 12'h7FF, 1'b1, 3'd0, 8'h01, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 12'd5,   1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 12'd5,   1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        add_cycle(1'b1);
        add(1'b1, 1'b1, 1'b0, 12'd5, 1'b1, 3'd0, 8'h01, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 12'd5, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);

        #2;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rem", 32'(rem_bcd), 32'h00);
        chk("reset_led", 32'(phase_led), 32'd0);
        chk("reset_pulses", {29'd0, charge, reject, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            @(negedge clk);
            start = v.st; on = v.en; abort = v.ab; bal = v.b;
            step();
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(v.bz));
            chk($sformatf("vec%0d_phase", i), 32'(phase), 32'(v.ph));
            chk($sformatf("vec%0d_rem", i), 32'(rem_bcd), 32'(v.rm));
            chk($sformatf("vec%0d_led", i), 32'(phase_led), v.bz ? (32'd1 << v.ph) : 32'd0);
            chk($sformatf("vec%0d_pulses", i), {29'd0, charge, reject, done}, {29'd0, v.chg, v.rej, v.dn});
        end

        // Pause in phase 1 for 10 clk: state frozen, done 10 clk later than usual
        @(negedge clk);
        start = 1'b1; on = 1'b1; abort = 1'b0; bal = 12'd5;
        step();
        chk("pause_charge", 32'(charge), 32'd1);
        @(negedge clk);
        start = 1'b0;
        repeat (6) step();
        chk("pause_pre_phase", 32'(phase), 32'd1);
        chk("pause_pre_rem", 32'(rem_bcd), 32'h03);
        @(negedge clk);
        on = 1'b0;
        repeat (10) step();
        chk("pause_phase", 32'(phase), 32'd1);
        chk("pause_rem", 32'(rem_bcd), 32'h03);
        chk("pause_busy", 32'(busy), 32'd1);
        @(negedge clk);
        on = 1'b1;
        cnt = 0;
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            step();
            cnt++;
            seen = done;
        end
        chk("pause_done_seen", 32'(seen), 32'd1);
        chk("pause_total_clk", 32'(6 + 10 + cnt), 32'd34);
        step();

        // Zero-length lane runs one tick, 99 lane shows 99 then 98
        @(negedge clk);
        start2 = 1'b1;
        step();
        chk("lane_charge", 32'(charge2), 32'd1);
        chk("lane0_rem", 32'(rem_bcd2), 32'h01);
        @(negedge clk);
        start2 = 1'b0;
        repeat (2) step();
        chk("lane1_phase", 32'(phase2), 32'd1);
        chk("lane1_rem99", 32'(rem_bcd2), 32'h99);
        chk("lane1_led", 32'(phase_led2), 32'h02);
        repeat (2) step();
        chk("lane1_rem98", 32'(rem_bcd2), 32'h98);
        @(negedge clk);
        abort = 1'b1;
        step();
        chk("lane_abort_busy", 32'(busy2), 32'd0);
        chk("lane_abort_done", 32'(done2), 32'd0);
        @(negedge clk);
        abort = 1'b0;

        // Asynchronous reset in the middle of a run
        @(negedge clk);
        start = 1'b1;
        step();
        chk("rst_pre_busy", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0;
        repeat (3) step();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_async_busy", 32'(busy), 32'd0);
        chk("rst_async_rem", 32'(rem_bcd), 32'h00);
        chk("rst_async_led", 32'(phase_led), 32'd0);
        chk("rst_async_phase", 32'(phase), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("rst_after_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wash_cycle_ctrl.md
Name: wash_cycle_ctrl

Overview:
Parametrised multi-phase wash sequencer with per-start billing. Generalises the single fill/drain counter to NPHASE programmable phases: configurable tick divider, balance check and charge, pause/resume and abort. Sits between the coin/balance logic (supplies bal) and the 7-segment scanner and status LEDs (consumes rem_bcd and phase_led).

Parameters:
TICK_DIV, 100000000, clk cycles per 1 s tick (>=2)
NPHASE, 3, number of wash phases (1..8)
PHASE_SEC, {8'd10,8'd30,8'd20}, packed 8 b/phase; phase k duration in s = bits [8k+7:8k]; legal 1..99, 0 treated as 1
PRICE, 5, cost of one cycle, unsigned, < 2^(BAL_W-1)
BAL_W, 12, balance width, signed

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  request new cycle, level-sampled
on  in  1  run enable; low = pause
abort  in  1  cancel running cycle
bal  in  BAL_W  current balance, signed two's complement
busy  out  1  cycle in progress (RUN state)
phase  out  3  current phase index
phase_led  out  8  one-hot of phase in bits [NPHASE-1:0], upper bits 0
rem_bcd  out  8  remaining seconds in phase, 2 BCD digits {tens,units}
charge  out  1  1-cycle pulse: upstream deducts PRICE
reject  out  1  1-cycle pulse: start refused (insufficient balance)
done  out  1  1-cycle pulse: last phase finished

Behaviour:
- Reset (async, rst=1): state IDLE, divider 0, phase 0, rem 0. All outputs 0: busy, phase_led, rem_bcd=8'h00, charge, reject, done.
- States: IDLE, RUN, DONE. All outputs registered.
- IDLE, start=1, abort=0:
  - signed(bal) >= PRICE: next cycle state RUN, phase=0, rem=PHASE_SEC[0], divider=0, charge=1 for exactly that cycle.
  - otherwise: stay IDLE, reject=1 for one cycle. Negative bal always rejects.
- start held high re-evaluates only after returning to IDLE. start while RUN or DONE is ignored (no charge, no reject).
- RUN:
  - Divider advances only when on=1; on=0 freezes divider, rem and phase, busy stays 1.
  - Tick when divider==TICK_DIV-1 and on=1; divider wraps to 0.
  - On tick: rem>1 -> rem-1. rem==1 and phase<NPHASE-1 -> phase+1, rem=next PHASE_SEC. rem==1 and last phase -> DONE.
- DONE: done=1 for one cycle, busy=0, rem=0, phase_led=0; next cycle IDLE.
- abort=1 in RUN: next cycle IDLE, outputs as reset values, no done, no refund. abort in IDLE suppresses start (abort wins over start).
- Output encoding: rem_bcd = BCD(rem), range 00..99. phase_led = 1<<phase while busy, else 0.
- Reaching the first phase needs one accept cycle. Total cycle length = sum(PHASE_SEC)*TICK_DIV clk cycles of on=1 after charge.
- rst mid-cycle: immediate return to reset values; the charge already issued is not reversed.

Test Plan:
1. TICK_DIV=4, PHASE_SEC={2,3,1}, bal=5, start pulse -> charge at cycle 1. rem_bcd 01 -> phase 1 rem 03,02,01 -> phase 2 rem 02,01, advancing every 4 clk. done pulse after 24 clk; busy 1 throughout.
2. bal=4, start -> reject pulse, no charge, busy 0. bal=-1 -> reject. bal=12'h7FF -> accept.
3. Mid phase 1, on=0 for 10 clk -> rem and phase frozen. on=1 -> resumes with divider value intact; done delayed by exactly 10 clk.
4. abort in RUN -> busy 0 next cycle, no done. abort and start together in IDLE -> no charge, no reject.
5. start held high through the entire cycle -> exactly one charge per cycle; second charge only after DONE->IDLE. rst asserted mid-RUN -> outputs zero asynchronously.
6. PHASE_SEC lane =0 and a lane =99 -> phase lasts 1 tick; rem_bcd shows 8'h99 then 8'h98.
